// File: rtl/bram_pkg.sv
// Shared constants and FSM encoding for the BRAM-to-AXI-Stream reader.
package bram_pkg;

   localparam int BRAM_DW    = 128;
   localparam int BRAM_WL    = 256;
   localparam int ADDR_SHIFT = 2;
   localparam int ADDR_W     = 13;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with a registered head; a full FIFO accepts a push only alongside a pop.
module skid_fifo2 #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] e0;
   logic [W-1:0] e1;
   logic [1:0]   cnt;
   logic         pop_ok;
   logic         push_ok;

   assign pop_ok  = pop && (cnt != 2'd0);
   assign push_ok = push && ((cnt != 2'd2) || pop_ok);
   assign dout    = e0;
   assign full    = (cnt == 2'd2);
   assign empty   = (cnt == 2'd0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         e0  <= '0;
         e1  <= '0;
         cnt <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (cnt == 2'd0) e0 <= din;
               else             e1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               // head leaves; the new word lands behind whatever remains
               if (cnt == 2'd1) begin
                  e0 <= din;
               end else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Streams len consecutive BRAM words (wrapping at WL) starting at base_idx out of an AXI-Stream master.
//
// state    | meaning
// ST_IDLE  | waiting for start; the first read is issued in the start cycle itself
// ST_RUN   | issuing reads while the FIFO has room
// ST_DRAIN | all reads issued, waiting for the last beat to handshake
module bram_stream_reader
   import bram_pkg::*;
#(
   parameter int DW = BRAM_DW,
   parameter int WL = BRAM_WL
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [7:0]        base_idx,
   input  logic [8:0]        len,
   output logic              busy,
   output logic              done,
   output logic              bram_EN,
   output logic [3:0]        bram_WE,
   output logic [ADDR_W-1:0] bram_A,
   output logic [DW-1:0]     bram_Di,
   input  logic [DW-1:0]     bram_Do,
   output logic [DW-1:0]     m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready
);

   localparam int IW = $clog2(WL);

   state_t            state;
   logic [8:0]        len_q;
   logic [8:0]        iss_cnt;
   logic [8:0]        iss_cnt_n;
   logic [IW-1:0]     rd_idx;
   logic [IW-1:0]     issue_idx;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] a_q;
   logic              rd_pend;
   logic              rd_last;
   logic              issue;
   logic              issue_last;
   logic              start_go;
   logic              run_go;
   logic              credit;
   logic              pop;
   logic [1:0]        occ;
   logic [1:0]        load;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DW:0]       fifo_dout;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      return (idx == IW'(WL - 1)) ? '0 : idx + IW'(1);
   endfunction

   assign bram_WE = 4'b0000;
   assign bram_Di = '0;

   assign m_tvalid = !fifo_empty;
   assign m_tdata  = fifo_dout[DW-1:0];
   assign m_tlast  = m_tvalid && fifo_dout[DW];
   assign pop      = m_tvalid && m_tready;

   // in-flight read plus buffered words, with this cycle's pop already freed
   assign occ    = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
   assign load   = occ - {1'b0, pop} + {1'b0, rd_pend};
   assign credit = (load < 2'd2);

   assign start_go  = (state == ST_IDLE) && start && (len != 9'd0);
   assign run_go    = (state == ST_RUN) && (iss_cnt != len_q) && credit;
   assign issue     = !RST && (start_go || run_go);
   assign iss_cnt_n = iss_cnt + {8'd0, issue};

   assign issue_last = (state == ST_IDLE) ? (len == 9'd1) : (iss_cnt == len_q - 9'd1);
   assign issue_idx  = (state == ST_IDLE) ? IW'(base_idx) : rd_idx;
   assign issue_addr = ADDR_W'(issue_idx) << ADDR_SHIFT;

   // the address is presented combinationally so the first read goes out in the start cycle
   assign bram_A  = issue ? issue_addr : a_q;
   assign bram_EN = !RST && (issue || rd_pend);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         len_q   <= 9'd0;
         iss_cnt <= 9'd0;
         rd_idx  <= '0;
         rd_pend <= 1'b0;
         rd_last <= 1'b0;
         a_q     <= '0;
      end else begin
         done    <= 1'b0;
         rd_pend <= issue;
         rd_last <= issue && issue_last;
         if (issue) a_q <= issue_addr;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len == 9'd0) begin
                     done <= 1'b1;
                  end else begin
                     state   <= ST_RUN;
                     busy    <= 1'b1;
                     len_q   <= len;
                     iss_cnt <= 9'd1;
                     rd_idx  <= next_idx(IW'(base_idx));
                  end
               end
            end
            ST_RUN: begin
               if (issue) begin
                  iss_cnt <= iss_cnt_n;
                  rd_idx  <= next_idx(rd_idx);
               end
               if (iss_cnt_n == len_q) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && m_tlast) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   skid_fifo2 #(.W(DW + 1)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (rd_pend),
      .din   ({rd_last, bram_Do}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed and randomized transfers against a BRAM model and a queue-based expected-beat reference.
module tb_bram_stream_reader;

   localparam int DW = 128;

   logic          CLK = 1'b0;
   logic          RST;
   logic          start;
   logic [7:0]    base_idx;
   logic [8:0]    len;
   logic          busy;
   logic          done;
   logic          bram_EN;
   logic [3:0]    bram_WE;
   logic [12:0]   bram_A;
   logic [DW-1:0] bram_Di;
   logic [DW-1:0] bram_Do;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready;

   always #5 CLK = ~CLK;

   bram_stream_reader #(.DW(DW), .WL(256)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .start    (start),
      .base_idx (base_idx),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .bram_EN  (bram_EN),
      .bram_WE  (bram_WE),
      .bram_A   (bram_A),
      .bram_Di  (bram_Di),
      .bram_Do  (bram_Do),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready)
   );

   // BRAM: one-cycle read latency, output gated by the enable
   logic [DW-1:0] mem [256];
   logic [DW-1:0] bram_q;
   always @(posedge CLK) if (bram_EN) bram_q <= mem[bram_A[9:2]];
   assign bram_Do = bram_EN ? bram_q : '0;

   int tests = 0;
   int fails = 0;
   int mode, cyc, start_cyc;
   int beats, issued, done_cnt, done_cyc, first_v, last_cyc;
   logic [DW-1:0] exp_q[$];
   bit            exp_lq[$];
   logic [12:0]   alog[$];
   bit            have_a;
   logic [12:0]   last_a;
   bit            pv, pr;
   logic [DW-1:0] pd;
   logic          pl;
   bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      tests++;
      assert (obs == exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive ready, sample the settled outputs, then advance
   task automatic step();
      case (mode)
         0:       m_tready = 1'b1;
         1:       m_tready = pat[(cyc - start_cyc) % 4];
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
      #2;
      if (RST) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            chkb("hold_valid", m_tvalid, 1'b1);
            chk("hold_data", m_tdata, pd);
            chkb("hold_last", m_tlast, pl);
         end
         if (m_tvalid && first_v < 0) first_v = cyc;
         if (bram_EN && (!have_a || bram_A !== last_a)) begin
            alog.push_back(bram_A);
            last_a = bram_A;
            have_a = 1'b1;
            issued++;
         end
         if (m_tvalid && m_tready) begin
            chkb("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               chk("tdata", m_tdata, exp_q[0]);
               chkb("tlast", m_tlast, exp_lq[0]);
               void'(exp_q.pop_front());
               void'(exp_lq.pop_front());
            end
            beats++;
            if (m_tlast) last_cyc = cyc;
         end
         if (bram_EN) chkb("outstanding_le2", (issued - beats) <= 2, 1'b1);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
      end
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic clear_stats(input int m);
      mode = m;
      exp_q.delete(); exp_lq.delete(); alog.delete();
      have_a = 1'b0; beats = 0; issued = 0; done_cnt = 0;
      done_cyc = -1; first_v = -1; last_cyc = -1; pv = 1'b0;
   endtask

   task automatic load_expect(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mem[(base + i) % 256]);
         exp_lq.push_back(i == n - 1);
      end
   endtask

   task automatic run_xfer(input int base, input int n, input int m, input bit poke);
      clear_stats(m);
      load_expect(base, n);
      base_idx  = 8'(base);
      len       = 9'(n);
      start     = 1'b1;
      start_cyc = cyc;
      step();
      start = 1'b0;
      while (done_cnt == 0 && cyc - start_cyc < 30 * n + 40) begin
         if (poke && cyc == start_cyc + 3) begin
            chkb("busy_when_poked", busy, 1'b1);
            start = 1'b1; base_idx = 8'd77; len = 9'd3;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      repeat (3) step();
      chki("done_count", done_cnt, 1);
      chki("beats_left", exp_q.size(), 0);
      chki("beats_total", beats, n);
      chki("done_after_last", done_cyc, last_cyc + 1);
      chkb("busy_end", busy, 1'b0);
      if (m == 0) begin
         chki("first_valid_lat", first_v - start_cyc, 2);
         chki("last_beat_lat", last_cyc - start_cyc, n + 1);
         chki("done_lat", done_cyc - start_cyc, n + 2);
      end
      chki("reads_issued", alog.size(), n);
      for (int i = 0; i < alog.size() && i < n; i++)
         chki("bram_A", int'(alog[i]), ((base + i) % 256) * 4);
   endtask

   initial begin
      int b, n, beats_keep, issued_keep;
      for (int k = 0; k < 256; k++) mem[k] = {$urandom, $urandom, $urandom, 32'(k)};
      RST = 1'b1; start = 1'b0; base_idx = '0; len = '0; m_tready = 1'b1;
      cyc = 0; start_cyc = 0; clear_stats(0);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_done", done, 1'b0);
      chkb("rst_en", bram_EN, 1'b0);
      chki("rst_addr", int'(bram_A), 0);
      chkb("rst_tvalid", m_tvalid, 1'b0);
      chkb("rst_tlast", m_tlast, 1'b0);
      chk("rst_tdata", m_tdata, '0);
      chki("rst_we", int'(bram_WE), 0);
      chk("rst_di", bram_Di, '0);
      @(posedge CLK);
      #1;

      run_xfer(0, 4, 0, 1'b0);
      run_xfer(254, 4, 0, 1'b1);
      run_xfer($urandom_range(0, 255), 8, 1, 1'b0);

      // zero-length start: done next cycle, nothing else
      clear_stats(0);
      base_idx = 8'd5; len = 9'd0; start = 1'b1; start_cyc = cyc;
      step();
      start = 1'b0;
      repeat (4) step();
      chki("len0_done_count", done_cnt, 1);
      chki("len0_done_lat", done_cyc - start_cyc, 1);
      chki("len0_no_valid", first_v, -1);
      chki("len0_no_reads", issued, 0);
      chkb("len0_busy", busy, 1'b0);

      run_xfer(0, 256, 0, 1'b0);

      // reset while beat 3 of a 10-word transfer is on the bus
      b = $urandom_range(0, 255);
      clear_stats(0);
      load_expect(b, 10);
      base_idx = 8'(b); len = 9'd10; start = 1'b1; start_cyc = cyc;
      step();
      start = 1'b0;
      while (beats < 3 && cyc - start_cyc < 40) step();
      chki("beats_before_rst", beats, 3);
      RST = 1'b1;
      step();
      RST = 1'b0;
      #1;
      chkb("rst_mid_tvalid", m_tvalid, 1'b0);
      chkb("rst_mid_busy", busy, 1'b0);
      exp_q.delete(); exp_lq.delete();
      done_cnt = 0; beats_keep = beats; issued_keep = issued;
      repeat (6) step();
      chki("rst_mid_no_done", done_cnt, 0);
      chki("rst_mid_no_beats", beats, beats_keep);
      chki("rst_mid_no_reads", issued, issued_keep);
      run_xfer($urandom_range(0, 255), 2, 0, 1'b0);

      for (int t = 0; t < 4; t++) begin
         b = $urandom_range(0, 255);
         n = $urandom_range(1, 20);
         run_xfer(b, n, 2, 1'b0);
      end

      chki("we_const", int'(bram_WE), 0);
      chk("di_const", bram_Di, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameters SHALL be: DW, 128, data word width; WL, 256, BRAM depth in words.
REQ-002 Port CLK, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-003 Port RST, input, 1: reset; synchronous, active-high.
REQ-004 Port start, input, 1: a one-cycle pulse that launches a transfer.
REQ-005 Port base_idx, input, 8: first word index, sampled on start.
REQ-006 Port len, input, 9: word count 0..256, sampled on start.
REQ-007 Port busy, output, 1: high from the accepted start until the final beat handshakes.
REQ-008 Port done, output, 1: one-cycle pulse on the cycle after the final beat handshakes.
REQ-009 Ports bram_EN (output, 1), bram_WE (output, 4), bram_A (output, 13) and bram_Di (output, DW) SHALL drive the BRAM port.
REQ-010 Port bram_Do, input, DW: BRAM read data.
REQ-011 Ports m_tdata (output, DW), m_tvalid (output, 1), m_tlast (output, 1) and m_tready (input, 1) SHALL form the AXI-Stream master.

Function
REQ-012 bram_WE SHALL be constant 4'b0000, and bram_Di SHALL be constant zero.
REQ-013 For the i-th read, bram_A SHALL be ((base_idx + i) mod WL) << 2.
- BRAM word select is bram_A >> 2.
- The index wraps 255 -> 0.
REQ-014 Read data SHALL be valid on bram_Do in the cycle after the address is presented.
- bram_EN SHALL be high in both the issue cycle and the capture cycle, because the BRAM gates bram_Do with bram_EN.
REQ-015 The FSM SHALL have three states.
- IDLE: waits for start.
- RUN: issues reads.
- DRAIN: all reads issued, waiting for the buffer to empty.
REQ-016 Transitions:
- IDLE -> RUN on start with len != 0.
- RUN -> DRAIN after the len-th read is issued.
- DRAIN -> IDLE when the final beat handshakes.
REQ-017 start with len == 0 SHALL leave the FSM in IDLE, issue no reads and no beats, and pulse done on the next cycle.
REQ-018 start SHALL be ignored while busy is high.
REQ-019 Output buffering SHALL be a 2-entry FIFO.
- A read is issued only when (in-flight reads + occupied entries) < 2, counting a same-cycle pop as freeing an entry.
REQ-020 With m_tready held high, the block SHALL sustain one beat per cycle.
- First m_tvalid SHALL rise 2 cycles after start.
- The last beat SHALL leave len+1 cycles after start.
REQ-021 m_tdata, m_tvalid and m_tlast SHALL be stable while m_tvalid is high and m_tready is low.
REQ-022 m_tlast SHALL be high only on beat len-1.
REQ-023 Word counters SHALL be 9 bits wide so that len == 256 covers the full BRAM exactly once.

Reset
REQ-024 On RST, the block SHALL reset synchronously:
- busy = 0, done = 0, bram_EN = 0, bram_A = 0;
- m_tvalid = 0, m_tlast = 0, m_tdata = 0;
- FIFO empty, counters zero, FSM in IDLE.
REQ-025 RST mid-transfer SHALL abort the transfer.
- No further beats and no done pulse.
- In-flight read data SHALL be discarded.

Structure
REQ-026 Shared package bram_pkg SHALL hold DW, WL, the address shift (2), the address width (13) and the FSM state encoding.
REQ-027 The 2-entry FIFO SHALL be the sub-module skid_fifo2 (push, pop, full, empty, parameterised width); all other logic SHALL be flat.

Verification
REQ-028 Preload word k = k. Stimulus: base_idx=0, len=4, m_tready=1. Response: beats 0,1,2,3; tlast on 3; done 6 cycles after start.
REQ-029 Wrap. Stimulus: base_idx=254, len=4. Response: beats 254,255,0,1; bram_A sequence 0x3F8, 0x3FC, 0x000, 0x004.
REQ-030 Backpressure. Stimulus: len=8, m_tready toggling 1,0,0,1. Response: all 8 beats in order, none dropped or duplicated, tdata stable while stalled, at most 2 reads in flight plus buffered.
REQ-031 Edges:
- len=0: done the next cycle, no tvalid.
- len=256, base=0: 256 beats, tlast on word 255.
- A second start while busy is ignored.
REQ-032 Stimulus: RST at beat 3 of len=10. Response: tvalid=0 and busy=0 the next cycle, no done; a new start with len=2 then completes normally.
